// File: rtl/fwd_scoreboard_unit.sv
// Shift-register scoreboard for EX operand forwarding and load-use stall.
// Optional STALL_CNT_EN adds a saturating stall_cnt output.
module fwd_scoreboard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ex_valid,
  input  logic [REG_ADDR_W-1:0]         ex_rd,
  input  logic                          ex_regwrite,
  input  logic                          ex_is_load,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic                          hold,
  input  logic                          flush,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
`ifdef STALL_CNT_EN
  output logic [15:0]                   stall_cnt,
`endif
  output logic                          stall
);

  logic [NUM_STAGES:1]   e_valid;
  logic [NUM_STAGES:1]   e_wr;
  logic [NUM_STAGES:1]   e_ld;
  logic [REG_ADDR_W-1:0] e_rd [1:NUM_STAGES];
  logic [NUM_SRC-1:0]    not_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= '0;
      e_wr    <= '0;
      e_ld    <= '0;
      for (int s = 1; s <= NUM_STAGES; s++)
        e_rd[s] <= '0;
    end else if (flush) begin
      e_valid <= '0;
    end else if (!hold) begin
      for (int s = 2; s <= NUM_STAGES; s++) begin
        e_valid[s] <= e_valid[s-1];
        e_wr[s]    <= e_wr[s-1];
        e_ld[s]    <= e_ld[s-1];
        e_rd[s]    <= e_rd[s-1];
      end
      // a stalled ID means the EX slot becomes a bubble
      e_valid[1] <= ex_valid & ~stall;
      e_wr[1]    <= ex_regwrite;
      e_ld[1]    <= ex_is_load;
      e_rd[1]    <= ex_rd;
    end
  end

  // oldest stage first so the youngest matching writer overrides
  always_comb begin
    fwd_sel   = '0;
    not_ready = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int s = NUM_STAGES; s >= 1; s--) begin
        if (e_valid[s] && e_wr[s] &&
            (e_rd[s] != '0) &&
            (e_rd[s] ==
             src_addr[k*REG_ADDR_W +: REG_ADDR_W])) begin
          fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(s);
          not_ready[k] = e_ld[s] && (s < LOAD_STAGE);
        end
      end
    end
  end

  assign stall = |not_ready;

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && !hold && !flush &&
             (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
